cabac_value_refill: RTL and testbench
=====================================

Name: cabac_value_refill

Overview:
- Sequential state-holder and bitstream feeder that sits around the combinational regular-bin decode stage.
- Owns the arithmetic-decoder registers (range, value, bits-needed counter).
- Initialises them from the slice bitstream and presents them to the bin decoder.
- Commits each decoded bin's new range/value and refills value with one bitstream byte whenever the bits-needed counter crosses zero, following VVC CABAC decoder semantics.

Parameters:
- RANGE_W, 9, width of range registers/ports.
- VALUE_W, 16, width of value registers/ports; all value arithmetic is modulo 2^VALUE_W.
- INIT_RANGE, 510, range loaded at slice init.
- BN_W, 5, width of signed bits-needed counter (two's complement).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin slice init; 1-cycle pulse.
- byte_in  in  8  bitstream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  block accepts byte_in this cycle.
- bin_valid  in  1  bin decoder result to commit this cycle.
- range_in  in  RANGE_W  new range from bin decoder.
- value_in  in  VALUE_W  new value from bin decoder.
- num_bits_in  in  3  renorm bit count from bin decoder.
- lps_in  in  1  1 = LPS path taken.
- no_renorm_in  in  1  1 = MPS range >= 256, no renormalisation.
- range_out  out  RANGE_W  current range to bin decoder.
- value_out  out  VALUE_W  current value to bin decoder.
- ctx_ready  out  1  range_out/value_out valid; bin decoder may commit.
- bits_needed  out  BN_W  current signed bits-needed counter.

Behaviour:
- Clocking: single clock; all state updates on rising clk edge; rst synchronous, active-high.
- Reset values: state=IDLE; range_out=0; value_out=0; bits_needed=-8; byte_ready=0; ctx_ready=0.
- FSM states:
  - IDLE: outputs held; on start -> INIT0.
  - INIT0: byte_ready=1; on byte_valid: value<={byte_in,8'h00}, range<=INIT_RANGE, bits_needed<=-8 -> INIT1.
  - INIT1: byte_ready=1; on byte_valid: value[7:0]<=byte_in -> READY.
  - READY: ctx_ready=1, byte_ready=0. On bin_valid:
    - shift = (lps_in | ~no_renorm_in) ? num_bits_in : 0.
    - bn = bits_needed + shift, computed signed.
    - range<=range_in; value<=value_in; bits_needed<=bn.
    - If bn >= 0 -> REFILL, else stay READY.
  - REFILL: ctx_ready=0, byte_ready=1; on byte_valid: value<=value + (byte_in << bits_needed), bits_needed<=bits_needed-8 -> READY.
- Handshakes:
  - A byte transfers only when byte_valid & byte_ready in the same cycle.
  - byte_valid with byte_ready=0 is not consumed.
  - bin_valid with ctx_ready=0 is ignored; no state change.
- Latency:
  - Commit visible on outputs the cycle after bin_valid.
  - After a refill byte is accepted in cycle M, ctx_ready=1 in cycle M+1.
  - Minimum back-to-back: one bin per cycle while no refill is needed.
- Ranges and widths:
  - bits_needed stays in [-8,-1] in READY and in [0,5] in REFILL.
  - Byte shift is at most 5, so the shifted byte fits 13 bits; the sum is truncated to VALUE_W.
- Boundary conditions:
  - bn exactly 0 -> REFILL; byte added unshifted; bits_needed becomes -8.
  - shift=0 with bin_valid -> registers updated, bits_needed unchanged.
- Priority: rst > start > all else. start in any state aborts the current operation, clears ctx_ready, and goes to INIT0 next cycle. start in the same cycle as bin_valid or byte_valid discards them.

Optional Feature:
- Macro: CABAC_REFILL_STATS_EN.
- When defined:
  - Adds outputs stall_cycles[31:0] and refill_count[31:0], both reset to 0 by rst or start.
  - stall_cycles increments every cycle in REFILL with byte_valid=0.
  - refill_count increments on each accepted REFILL byte.
  - Both counters saturate at 2^32-1.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
- rst, start, bytes 0xA5 then 0x3C (byte_valid held) -> range_out=510, value_out=0xA53C, bits_needed=-8, ctx_ready=1 the cycle after the second byte.
- From init: bin_valid, lps_in=1, num_bits_in=3, range_in=0x140, value_in=0x29E0 -> range_out=0x140, value_out=0x29E0, bits_needed=-5, ctx_ready stays 1, byte_ready=0.
- bits_needed=-3, bin_valid, lps_in=1, num_bits_in=6, value_in=0x1000 -> REFILL with bits_needed=3. Byte 0x81 -> value_out=0x1408, bits_needed=-5, ctx_ready=1 the next cycle.
- bits_needed=-6, num_bits_in=6, lps_in=1, value_in=0x0100 -> bn=0. Byte 0xFF -> value_out=0x01FF, bits_needed=-8.
- lps_in=0, no_renorm_in=1, num_bits_in=4 -> bits_needed unchanged, no REFILL. Also: bin_valid while in REFILL -> ignored.
- rst asserted during REFILL, and separately start asserted in READY -> outputs return to reset values / ctx_ready=0 and INIT0 the next cycle. A pending byte_valid is not consumed in the start cycle.

Source files
------------

// File: rtl/cabac_value_refill.sv
// +--------------------------------------------------------------------------+
// | cabac_value_refill: CABAC range/value/bits-needed owner with byte refill |
// | Optional: CABAC_REFILL_STATS_EN adds stall/refill counters               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cabac_value_refill #(
  parameter int RANGE_W    = 9,
  parameter int VALUE_W    = 16,
  parameter int INIT_RANGE = 510,
  parameter int BN_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [7:0]         i_byte_in,
  input  logic               i_byte_valid,
  output logic               o_byte_ready,
  input  logic               i_bin_valid,
  input  logic [RANGE_W-1:0] i_range_in,
  input  logic [VALUE_W-1:0] i_value_in,
  input  logic [2:0]         i_num_bits_in,
  input  logic               i_lps_in,
  input  logic               i_no_renorm_in,
  output logic [RANGE_W-1:0] o_range_out,
  output logic [VALUE_W-1:0] o_value_out,
  output logic               o_ctx_ready,
  output logic [BN_W-1:0]    o_bits_needed
`ifdef CABAC_REFILL_STATS_EN
  ,
  output logic [31:0]        o_stall_cycles,
  output logic [31:0]        o_refill_count
`endif
);

  localparam logic [BN_W-1:0] c_BN_INIT = BN_W'(-8);
  localparam logic [BN_W-1:0] c_BN_STEP = BN_W'(8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT0  = 3'd1,
    S_INIT1  = 3'd2,
    S_READY  = 3'd3,
    S_REFILL = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [RANGE_W-1:0] r_range;
  logic [VALUE_W-1:0] r_value;
  logic [BN_W-1:0]    r_bn;

  logic               w_byte_ready;
  logic               w_ctx_ready;
  logic               w_load_hi;
  logic               w_load_lo;
  logic               w_commit;
  logic               w_refill_acc;
  logic [2:0]         w_shift;
  logic [BN_W-1:0]    w_bn_next;
  logic [VALUE_W-1:0] w_byte_shifted;

  // MPS without renormalisation consumes no bits.
  assign w_shift        = (i_lps_in | ~i_no_renorm_in) ? i_num_bits_in : 3'd0;
  assign w_bn_next      = r_bn + BN_W'(w_shift);
  assign w_byte_shifted = VALUE_W'(i_byte_in) << r_bn[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_byte_ready = 1'b0;
    w_ctx_ready  = 1'b0;
    w_load_hi    = 1'b0;
    w_load_lo    = 1'b0;
    w_commit     = 1'b0;
    w_refill_acc = 1'b0;
    // start pre-empts every state, so nothing is handshaken in its cycle.
    if (i_start) begin
      w_state_next = S_INIT0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_IDLE;
        end
        S_INIT0: begin
          w_byte_ready = 1'b1;
          if (i_byte_valid) begin
            w_load_hi    = 1'b1;
            w_state_next = S_INIT1;
          end
        end
        S_INIT1: begin
          w_byte_ready = 1'b1;
          if (i_byte_valid) begin
            w_load_lo    = 1'b1;
            w_state_next = S_READY;
          end
        end
        S_READY: begin
          w_ctx_ready = 1'b1;
          if (i_bin_valid) begin
            w_commit     = 1'b1;
            w_state_next = w_bn_next[BN_W-1] ? S_READY : S_REFILL;
          end
        end
        S_REFILL: begin
          w_byte_ready = 1'b1;
          if (i_byte_valid) begin
            w_refill_acc = 1'b1;
            w_state_next = S_READY;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_range <= '0;
      r_value <= '0;
      r_bn    <= c_BN_INIT;
    end else if (w_load_hi) begin
      r_value <= VALUE_W'({i_byte_in, 8'h00});
      r_range <= RANGE_W'(INIT_RANGE);
      r_bn    <= c_BN_INIT;
    end else if (w_load_lo) begin
      r_value[7:0] <= i_byte_in;
    end else if (w_commit) begin
      r_range <= i_range_in;
      r_value <= i_value_in;
      r_bn    <= w_bn_next;
    end else if (w_refill_acc) begin
      r_value <= r_value + w_byte_shifted;
      r_bn    <= r_bn - c_BN_STEP;
    end
  end

  assign o_range_out   = r_range;
  assign o_value_out   = r_value;
  assign o_bits_needed = r_bn;
  assign o_byte_ready  = w_byte_ready;
  assign o_ctx_ready   = w_ctx_ready;

`ifdef CABAC_REFILL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_refill_count;

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_stall_cycles <= '0;
      r_refill_count <= '0;
    end else begin
      if ((r_state == S_REFILL) && !i_byte_valid && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_refill_acc && (r_refill_count != '1)) begin
        r_refill_count <= r_refill_count + 32'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_refill_count = r_refill_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cabac_value_refill.sv
// Scoreboard bench for cabac_value_refill: directed test-plan sequence, then
// randomized traffic checked against an arithmetic model of the decoder state.
`default_nettype none

module tb_cabac_value_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        bin_valid = 1'b0;
  logic [8:0]  range_in = 9'h0;
  logic [15:0] value_in = 16'h0;
  logic [2:0]  num_bits_in = 3'd0;
  logic        lps_in = 1'b0;
  logic        no_renorm_in = 1'b0;
  logic [8:0]  range_out;
  logic [15:0] value_out;
  logic        ctx_ready;
  logic [4:0]  bits_needed;
`ifdef CABAC_REFILL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] refill_count;
`endif

  cabac_value_refill dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_byte_in      (byte_in),
    .i_byte_valid   (byte_valid),
    .o_byte_ready   (byte_ready),
    .i_bin_valid    (bin_valid),
    .i_range_in     (range_in),
    .i_value_in     (value_in),
    .i_num_bits_in  (num_bits_in),
    .i_lps_in       (lps_in),
    .i_no_renorm_in (no_renorm_in),
    .o_range_out    (range_out),
    .o_value_out    (value_out),
    .o_ctx_ready    (ctx_ready),
    .o_bits_needed  (bits_needed)
`ifdef CABAC_REFILL_STATS_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_refill_count (refill_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ctx;
    logic        br;
    logic [8:0]  rng;
    logic [15:0] val;
    logic [4:0]  bn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  localparam int M_IDLE = 0, M_INIT0 = 1, M_INIT1 = 2, M_READY = 3, M_REFILL = 4;
  int m_mode  = M_IDLE;
  int m_range = 0;
  int m_value = 0;
  int m_bn    = -8;

  task automatic model_step(input logic st, input logic bv, input logic [7:0] b,
                            input logic binv, input logic [8:0] r, input logic [15:0] v,
                            input logic [2:0] nb, input logic lps, input logic nr,
                            input logic rs);
    int sh;
    if (rs) begin
      m_mode = M_IDLE; m_range = 0; m_value = 0; m_bn = -8;
    end else if (st) begin
      m_mode = M_INIT0;
    end else begin
      case (m_mode)
        M_INIT0: if (bv) begin
          m_value = int'(b) * 256; m_range = 510; m_bn = -8; m_mode = M_INIT1;
        end
        M_INIT1: if (bv) begin
          m_value = (m_value / 256) * 256 + int'(b); m_mode = M_READY;
        end
        M_READY: if (binv) begin
          sh = (lps || !nr) ? int'(nb) : 0;
          m_bn = m_bn + sh; m_range = int'(r); m_value = int'(v);
          m_mode = (m_bn >= 0) ? M_REFILL : M_READY;
        end
        M_REFILL: if (bv) begin
          m_value = (m_value + int'(b) * (1 << m_bn)) % 65536;
          m_bn = m_bn - 8; m_mode = M_READY;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle; queue the outputs the DUT must show during it, then advance the model.
  task automatic apply(input logic st, input logic bv, input logic [7:0] b,
                       input logic binv, input logic [8:0] r, input logic [15:0] v,
                       input logic [2:0] nb, input logic lps, input logic nr,
                       input logic rs);
    exp_t e;
    logic [4:0] bn5;
    @(posedge clk); #1;
    rst = rs; start = st; byte_valid = bv; byte_in = b; bin_valid = binv;
    range_in = r; value_in = v; num_bits_in = nb; lps_in = lps; no_renorm_in = nr;
    if (!rs) begin
      mon_en = 1'b1;
      bn5    = m_bn[4:0];
      e.ctx  = (m_mode == M_READY) && !st;
      e.br   = ((m_mode == M_INIT0) || (m_mode == M_INIT1) || (m_mode == M_REFILL)) && !st;
      e.rng  = m_range[8:0];
      e.val  = m_value[15:0];
      e.bn   = bn5;
      sb.push_back(e);
    end
    model_step(st, bv, b, binv, r, v, nb, lps, nr, rs);
  endtask

  task automatic do_rst();   apply(0, 0, 8'($urandom), 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_start(); apply(1, 0, 8'($urandom), 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_idle();  apply(0, 0, 8'($urandom), 0, 9'($urandom), 16'($urandom), 0, 0, 0, 0); endtask
  task automatic do_byte(input logic [7:0] b); apply(0, 1, b, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_bin(input logic [8:0] r, input logic [15:0] v, input logic [2:0] nb,
                        input logic lps, input logic nr);
    apply(0, 0, 8'($urandom), 1, r, v, nb, lps, nr, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, expv);
    end
  endtask

  // Monitor: every non-reset cycle the DUT's outputs are compared with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: DUT output with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (ctx_ready !== e.ctx || byte_ready !== e.br || range_out !== e.rng ||
            value_out !== e.val || bits_needed !== e.bn) begin
          n_err++;
          $display("FAIL cycle_outputs @%0t: got ctx=%b br=%b range=%h value=%h bn=%0d, expected ctx=%b br=%b range=%h value=%h bn=%0d",
                   $time, ctx_ready, byte_ready, range_out, value_out, $signed(bits_needed),
                   e.ctx, e.br, e.rng, e.val, $signed(e.bn));
        end
      end
    end
  end

  initial begin
    int nb_max;
    do_rst(); do_rst();
    do_idle();
    @(negedge clk);
    chk("reset_range", range_out, 0);
    chk("reset_value", value_out, 0);
    chk("reset_bn", bits_needed, 5'h18);
    chk("reset_ctx_ready", ctx_ready, 0);
    chk("reset_byte_ready", byte_ready, 0);

    do_start(); do_byte(8'hA5); do_byte(8'h3C); do_idle();
    @(negedge clk);
    chk("init_range", range_out, 510);
    chk("init_value", value_out, 16'hA53C);
    chk("init_bn", bits_needed, 5'h18);
    chk("init_ctx_ready", ctx_ready, 1);

    do_bin(9'h140, 16'h29E0, 3, 1, 0); do_idle();
    @(negedge clk);
    chk("lps_range", range_out, 9'h140);
    chk("lps_value", value_out, 16'h29E0);
    chk("lps_bn", bits_needed, 5'h1B);
    chk("lps_ctx_ready", ctx_ready, 1);
    chk("lps_byte_ready", byte_ready, 0);

    do_bin(9'h150, 16'h29E0, 2, 1, 0);
    do_bin(9'h150, 16'h1000, 6, 1, 0); do_idle();
    @(negedge clk);
    chk("refill_bn", bits_needed, 5'd3);
    chk("refill_ctx_ready", ctx_ready, 0);
    chk("refill_byte_ready", byte_ready, 1);
    do_byte(8'h81); do_idle();
    @(negedge clk);
    chk("refill_value", value_out, 16'h1408);
    chk("refill_bn_after", bits_needed, 5'h1B);
    chk("refill_ctx_after", ctx_ready, 1);

    do_bin(9'h150, 16'h2222, 7, 1, 0);
    do_byte(8'h10);
    do_bin(9'h150, 16'h0100, 6, 1, 0); do_idle();
    @(negedge clk);
    chk("bn_zero_refill", bits_needed, 5'd0);
    do_byte(8'hFF); do_idle();
    @(negedge clk);
    chk("bn_zero_value", value_out, 16'h01FF);
    chk("bn_zero_bn_after", bits_needed, 5'h18);

    do_bin(9'h1AB, 16'h4321, 4, 0, 1); do_idle();
    @(negedge clk);
    chk("mps_norenorm_bn", bits_needed, 5'h18);
    chk("mps_norenorm_value", value_out, 16'h4321);
    chk("mps_norenorm_ctx", ctx_ready, 1);

    do_bin(9'h150, 16'h0202, 7, 1, 0);
    do_bin(9'h160, 16'h0303, 1, 1, 0);
    do_bin(9'h111, 16'h5555, 7, 1, 0); do_idle();
    @(negedge clk);
    chk("refill_bin_ignored_range", range_out, 9'h160);
    chk("refill_bin_ignored_value", value_out, 16'h0303);
    chk("refill_bin_ignored_bn", bits_needed, 5'd0);

    do_rst(); do_idle();
    @(negedge clk);
    chk("rst_in_refill_value", value_out, 0);
    chk("rst_in_refill_bn", bits_needed, 5'h18);
    chk("rst_in_refill_br", byte_ready, 0);

    do_start(); do_byte(8'h12); do_byte(8'h34);
    apply(1, 1, 8'h77, 1, 9'h100, 16'hBEEF, 3, 1, 0, 0);
    @(negedge clk);
    chk("start_cycle_byte_ready", byte_ready, 0);
    do_idle();
    @(negedge clk);
    chk("after_start_ctx", ctx_ready, 0);
    chk("after_start_br", byte_ready, 1);
    chk("after_start_value", value_out, 16'h1234);
    do_byte(8'h56); do_byte(8'h78);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_rst();
      end else if ($urandom_range(0, 79) == 0 || m_mode == M_IDLE) begin
        apply(1, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 9'($urandom),
              16'($urandom), 3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      end else if (m_mode == M_READY) begin
        nb_max = (5 - m_bn > 7) ? 7 : 5 - m_bn;
        apply(0, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 4) != 0,
              9'($urandom), 16'($urandom), 3'($urandom_range(0, nb_max)),
              $urandom_range(0, 1), $urandom_range(0, 1), 0);
      end else begin
        apply(0, $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 2) == 0,
              9'($urandom), 16'($urandom), 3'($urandom), $urandom_range(0, 1),
              $urandom_range(0, 1), 0);
      end
    end

    do_idle();
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
